onchip_memory_stream_loader: RTL and testbench
==============================================

// Module: onchip_memory_stream_loader
// PURPOSE
//  Upstream write master for the single-port on-chip RAM (32-bit words, 4 byte lanes, 51200 words).
//  Accepts a byte stream (valid/ready), packs bytes little-endian into 32-bit words, and writes
//  them to consecutive word addresses starting at a programmed base. Used for boot/image loading.
//  While busy=1, system muxing gives this block ownership of the RAM port.
// PARAMETERS
//  ADDR_W   16     RAM word-address width
//  DEPTH    51200  RAM depth in words; writes must not reach address >= DEPTH
//  LEN_W    18     width of byte_len (max 4*DEPTH bytes)
// PORTS
//  clk             in   1       system clock
//  reset_n         in   1       synchronous reset, active low
//  start           in   1       1-cycle request; sampled only in IDLE
//  base_addr       in   ADDR_W  first word address; sampled with start
//  byte_len        in   LEN_W   transfer length in bytes; sampled with start
//  s_data          in   8       stream byte
//  s_valid         in   1       stream byte valid
//  s_ready         out  1       byte accepted when s_valid & s_ready
//  mem_address     out  ADDR_W  RAM word address
//  mem_byteenable  out  4       RAM byte lanes
//  mem_chipselect  out  1       RAM select
//  mem_write       out  1       RAM write strobe
//  mem_writedata   out  32      RAM write data
//  mem_clken       out  1       RAM clock enable; constant 1 after reset
//  busy            out  1       1 outside IDLE
//  done            out  1       1-cycle pulse at end of transfer (success or error)
//  error           out  1       range error; valid with done, held until next start
//  words_written   out  ADDR_W  count of RAM writes this transfer
// BEHAVIOUR
//  Reset (reset_n=0 at a clk edge): state=IDLE; all outputs 0 except mem_clken=1. The partial word
//   is discarded, with no write. A reset mid-transfer aborts it with no done pulse.
//  States: IDLE, CHECK, FILL, WRITE, DONE.
//  IDLE: start=1 -> latch base/len, clear words_written/error/pack regs -> CHECK. start is ignored in other states.
//  CHECK (1 cycle): nwords=ceil(len/4), computed at ADDR_W+1 bits without wrap.
//   len==0 -> DONE, error=0. base+nwords>DEPTH -> DONE, error=1, no writes. Otherwise -> FILL.
//  FILL: s_ready=1. Each accepted byte goes to lane (byte_idx mod 4), and bits [8k+7:8k] take byte k.
//   Its lane bit is set in byteenable. Lanes not filled stay 0 in data and byteenable.
//   After the 4th byte of a word, or the final byte of len -> WRITE on the next cycle.
//  WRITE (1 cycle): s_ready=0; mem_chipselect=mem_write=1; mem_address=base+word_idx.
//   Data and byteenable come from the pack regs. words_written increments.
//   Then: bytes remaining -> FILL with pack regs cleared; else -> DONE.
//  DONE (1 cycle): done=1; busy=1 -> IDLE.
//  mem_chipselect/mem_write are 0 in every state except WRITE. mem_address/writedata are don't-care
//   when not writing but driven registered; no combinational path from s_* to mem_*.
//  Throughput: a full word takes 4 accept cycles + 1 write cycle. s_valid gaps stall FILL only.
//  Address arithmetic never wraps. The range check guarantees the last write is at address <= DEPTH-1.
//  The final partial word uses byteenable 0x1/0x3/0x7 for len mod 4 = 1/2/3.
// TESTING
//  T1 base=0x0010,len=8,bytes 01..08 continuous -> writes @0x0010 0x04030201 be=F, @0x0011
//     0x08070605 be=F; done pulse; error=0; words_written=2.
//  T2 base=0,len=6,bytes 01..06 -> @0 0x04030201 be=F; @1 0x00000605 be=3; done.
//  T3 base=51199,len=8 -> no mem_write ever; done=1 with error=1; s_ready stays 0.
//     base=51199,len=4 -> one write @51199, error=0.
//  T4 len=8, s_valid toggled randomly 50% -> identical writes to T1; no byte lost or duplicated.
//  T5 reset_n=0 after 3 bytes accepted -> no write, no done, outputs at reset values; a later
//     start with T1 stimulus -> T1 response.
//  T6 len=0 -> done 2 cycles after start with no write; a start pulse during busy -> ignored,
//     exactly one done.

Source files
------------

// File: rtl/onchip_memory_stream_loader.sv
// rtl/onchip_memory_stream_loader.sv - byte stream to 32-bit on-chip RAM word loader
// Packs stream bytes little-endian and writes consecutive words from a programmed base.
module onchip_memory_stream_loader #(
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 51200,
    parameter int LEN_W  = 18
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  byte_len,
    input  logic [7:0]        s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [ADDR_W-1:0] mem_address,
    output logic [3:0]        mem_byteenable,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [31:0]       mem_writedata,
    output logic              mem_clken,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W-1:0] words_written
);

    // Wide enough that base + word count can never wrap during the range check.
    localparam int SUM_W = ((ADDR_W > LEN_W) ? ADDR_W : LEN_W) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_FILL,
        S_WRITE,
        S_DONE
    } state_t;

    state_t            state_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  bytes_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       data_q;
    logic [3:0]        be_q;
    logic              s_ready_q;
    logic              wr_q;
    logic              busy_q;
    logic              done_q;
    logic              error_q;
    logic [ADDR_W-1:0] words_q;
    logic              clken_q;

    logic [1:0]        lane;
    logic [LEN_W-1:0]  bytes_d;
    logic [31:0]       data_d;
    logic [3:0]        be_d;
    logic              word_end;
    logic [SUM_W-1:0]  nwords;
    logic [SUM_W-1:0]  end_sum;
    logic              range_err;

    always_comb begin
        lane      = bytes_q[1:0];
        bytes_d   = bytes_q + LEN_W'(1);
        data_d    = data_q;
        data_d[{lane, 3'b000} +: 8] = s_data;
        be_d      = be_q | (4'b0001 << lane);
        word_end  = (lane == 2'd3) || (bytes_d == len_q);
        nwords    = (SUM_W'(len_q) + SUM_W'(3)) >> 2;
        end_sum   = SUM_W'(addr_q) + nwords;
        range_err = end_sum > SUM_W'(DEPTH);
    end

    always_ff @(posedge clk) begin
        clken_q <= 1'b1;
        if (!reset_n) begin
            state_q   <= S_IDLE;
            len_q     <= '0;
            bytes_q   <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            be_q      <= '0;
            s_ready_q <= 1'b0;
            wr_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            words_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        len_q   <= byte_len;
                        addr_q  <= base_addr;
                        bytes_q <= '0;
                        data_q  <= '0;
                        be_q    <= '0;
                        words_q <= '0;
                        error_q <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (len_q == '0) begin
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else if (range_err) begin
                        error_q <= 1'b1;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        s_ready_q <= 1'b1;
                        state_q   <= S_FILL;
                    end
                end
                S_FILL: begin
                    if (s_valid && s_ready_q) begin
                        data_q  <= data_d;
                        be_q    <= be_d;
                        bytes_q <= bytes_d;
                        if (word_end) begin
                            s_ready_q <= 1'b0;
                            wr_q      <= 1'b1;
                            state_q   <= S_WRITE;
                        end
                    end
                end
                S_WRITE: begin
                    // addr_q ends at base + nwords, which the range check keeps <= DEPTH.
                    wr_q    <= 1'b0;
                    words_q <= words_q + ADDR_W'(1);
                    addr_q  <= addr_q + ADDR_W'(1);
                    if (bytes_q != len_q) begin
                        data_q    <= '0;
                        be_q      <= '0;
                        s_ready_q <= 1'b1;
                        state_q   <= S_FILL;
                    end else begin
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign s_ready        = s_ready_q;
    assign mem_address    = addr_q;
    assign mem_byteenable = be_q;
    assign mem_chipselect = wr_q;
    assign mem_write      = wr_q;
    assign mem_writedata  = data_q;
    assign mem_clken      = clken_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign error          = error_q;
    assign words_written  = words_q;

endmodule

// File: tb/tb_onchip_memory_stream_loader.sv
// tb/tb_onchip_memory_stream_loader.sv - self-checking bench for onchip_memory_stream_loader
// Directed and randomized transfers compared against a word-packing reference model.
module tb_onchip_memory_stream_loader;

    localparam int DEPTH = 51200;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [15:0] base_addr;
    logic [17:0] byte_len;
    logic [7:0]  s_data;
    logic        s_valid;
    logic        s_ready;
    logic [15:0] mem_address;
    logic [3:0]  mem_byteenable;
    logic        mem_chipselect;
    logic        mem_write;
    logic [31:0] mem_writedata;
    logic        mem_clken;
    logic        busy;
    logic        done;
    logic        error;
    logic [15:0] words_written;

    always #5 clk = ~clk;

    onchip_memory_stream_loader dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .start          (start),
        .base_addr      (base_addr),
        .byte_len       (byte_len),
        .s_data         (s_data),
        .s_valid        (s_valid),
        .s_ready        (s_ready),
        .mem_address    (mem_address),
        .mem_byteenable (mem_byteenable),
        .mem_chipselect (mem_chipselect),
        .mem_write      (mem_write),
        .mem_writedata  (mem_writedata),
        .mem_clken      (mem_clken),
        .busy           (busy),
        .done           (done),
        .error          (error),
        .words_written  (words_written)
    );

    int          checks   = 0;
    int          failures = 0;
    logic [7:0]  tx [0:63];
    logic [51:0] got   [$];
    logic [51:0] exp_q [$];
    bit          exp_err;
    int          exp_ww;
    int          done_cnt;
    int          done_cyc;
    int          ready_cnt;
    int          cs_mismatch;
    int          idx;
    logic        err_at_done;
    logic [15:0] ww_at_done;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: byte i lands in word i/4, lane i%4; whole transfer rejected if it overruns the RAM.
    task automatic model(input int base, input int len);
        int          nw;
        logic [31:0] d;
        logic [3:0]  be;
        exp_q.delete();
        nw      = (len + 3) / 4;
        exp_err = (len != 0) && (base + nw > DEPTH);
        exp_ww  = exp_err ? 0 : nw;
        if (!exp_err) begin
            for (int w = 0; w < nw; w++) begin
                d  = '0;
                be = '0;
                for (int k = 0; k < 4; k++) begin
                    if (4 * w + k < len) begin
                        d[8*k +: 8] = tx[4*w + k];
                        be[k]       = 1'b1;
                    end
                end
                exp_q.push_back({16'(base + w), d, be});
            end
        end
    endtask

    task automatic sample_outputs(input int c);
        if (mem_write) got.push_back({mem_address, mem_writedata, mem_byteenable});
        if (mem_write !== mem_chipselect) cs_mismatch++;
        if (s_ready) ready_cnt++;
        if (done) begin
            done_cnt++;
            if (done_cyc < 0) begin
                done_cyc    = c;
                err_at_done = error;
                ww_at_done  = words_written;
            end
        end
    endtask

    task automatic clear_obs();
        got.delete();
        done_cnt    = 0;
        done_cyc    = -1;
        ready_cnt   = 0;
        cs_mismatch = 0;
        idx         = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ctl"}, {s_ready, mem_chipselect, mem_write, busy, done, error, mem_clken}, 7'b0000001);
        chk({tag, "_mem"}, {mem_address, mem_byteenable, mem_writedata}, 52'h0);
        chk({tag, "_words"}, words_written, 16'h0);
    endtask

    task automatic xfer(input string tag, input int base, input int len, input int vpct, input int extra_start_c);
        clear_obs();
        @(negedge clk);
        base_addr = base[15:0];
        byte_len  = len[17:0];
        start     = 1'b1;
        s_valid   = 1'b0;
        for (int c = 1; c <= 3000; c++) begin
            @(negedge clk);
            start = (c == extra_start_c);
            if (idx < len && int'($urandom_range(99)) < vpct) begin
                s_valid = 1'b1;
                s_data  = tx[idx];
            end else begin
                s_valid = 1'b0;
                s_data  = 8'($urandom);
            end
            sample_outputs(c);
            if (s_valid && s_ready) idx++;
            if (done_cyc >= 0 && c >= done_cyc + 4) break;
        end
        s_valid = 1'b0;
        start   = 1'b0;
        model(base, len);
        chk({tag, "_done_count"}, done_cnt, 1);
        chk({tag, "_error"}, err_at_done, exp_err);
        chk({tag, "_words_written"}, ww_at_done, exp_ww);
        chk({tag, "_write_count"}, got.size(), exp_q.size());
        chk({tag, "_cs_eq_write"}, cs_mismatch, 0);
        for (int i = 0; i < exp_q.size() && i < got.size(); i++)
            chk({tag, "_write_entry"}, got[i], exp_q[i]);
        if (exp_err) chk({tag, "_ready_in_error"}, ready_cnt, 0);
    endtask

    task automatic load_seq(input int n);
        for (int i = 0; i < 64; i++) tx[i] = (i < n) ? 8'(i + 1) : 8'h00;
    endtask

    task automatic load_rand();
        for (int i = 0; i < 64; i++) tx[i] = 8'($urandom);
    endtask

    initial begin
        reset_n   = 1'b0;
        start     = 1'b0;
        base_addr = '0;
        byte_len  = '0;
        s_data    = '0;
        s_valid   = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        reset_n = 1'b1;

        // T1: two full words, continuous stream
        load_seq(8);
        xfer("t1", 16'h0010, 8, 100, 0);
        chk("t1_w0_data", (got.size() > 0) ? got[0][35:4] : 32'hx, 32'h04030201);
        chk("t1_w1_addr", (got.size() > 1) ? got[1][51:36] : 16'hx, 16'h0011);

        // T2: trailing partial word
        load_seq(6);
        xfer("t2", 0, 6, 100, 0);
        chk("t2_w1_be", (got.size() > 1) ? got[1][3:0] : 4'hx, 4'h3);

        // T3: range overflow at the top of the RAM, then an exact fit
        load_rand();
        xfer("t3_over", DEPTH - 1, 8, 100, 0);
        xfer("t3_fit", DEPTH - 1, 4, 100, 0);

        // T4: gappy stream gives the T1 writes
        load_seq(8);
        xfer("t4", 16'h0010, 8, 50, 0);

        // T5: reset after three accepted bytes
        load_seq(8);
        clear_obs();
        @(negedge clk);
        base_addr = 16'h0010;
        byte_len  = 18'd8;
        start     = 1'b1;
        for (int c = 1; c <= 200 && idx < 3; c++) begin
            @(negedge clk);
            start   = 1'b0;
            s_valid = 1'b1;
            s_data  = tx[idx];
            sample_outputs(c);
            if (s_valid && s_ready) idx++;
        end
        chk("t5_bytes_sent", idx, 3);
        @(negedge clk);
        s_valid = 1'b0;
        reset_n = 1'b0;
        sample_outputs(0);
        @(negedge clk);
        sample_outputs(0);
        check_reset_outputs("t5_reset");
        @(negedge clk);
        reset_n = 1'b1;
        sample_outputs(0);
        chk("t5_no_write", got.size(), 0);
        chk("t5_no_done", done_cnt, 0);
        xfer("t5_after", 16'h0010, 8, 100, 0);

        // T6: zero length, with a start pulse while busy
        xfer("t6_len0", 16'h0100, 0, 100, 2);
        chk("t6_done_latency", done_cyc, 2);
        load_rand();
        xfer("t6_busy_start", 16'h0200, 8, 100, 5);

        // Randomized transfers, some aimed near the top of the RAM
        for (int r = 0; r < 10; r++) begin
            int b;
            int l;
            load_rand();
            l = int'($urandom_range(40));
            b = (r % 3 == 0) ? DEPTH - int'($urandom_range(12)) : int'($urandom_range(DEPTH - 1));
            xfer("rand", b, l, 30 + int'($urandom_range(70)), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
